i2c_eeprom_slave: RTL and testbench



---
 rtl/i2c_eeprom_pkg.sv | 25 ++
 rtl/i2c_bus_sync.sv | 42 ++++
 rtl/i2c_eeprom_slave.sv | 179 +++++++++++++++++
 tb/tb_i2c_eeprom_slave.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM target.
package i2c_eeprom_pkg;

  // FSM state encoding
  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_DEV       = 4'd1;
  localparam logic [3:0] ST_ACK_DEV   = 4'd2;
  localparam logic [3:0] ST_WADDR     = 4'd3;
  localparam logic [3:0] ST_ACK_WADDR = 4'd4;
  localparam logic [3:0] ST_WDATA     = 4'd5;
  localparam logic [3:0] ST_ACK_WDATA = 4'd6;
  localparam logic [3:0] ST_RDATA     = 4'd7;
  localparam logic [3:0] ST_MACK      = 4'd8;

  // Bus condition seen in a given clk cycle; START/STOP outrank data edges
  typedef enum logic [1:0] {
    DET_NONE  = 2'd0,
    DET_START = 2'd1,
    DET_STOP  = 2'd2
  } i2c_det_e;

  // R/W bit value selecting a read transfer
  localparam logic I2C_RW_READ = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus edge and START/STOP detection.
// Both lines reset to 1 so an idle bus produces no spurious events.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_q, sda_q;
  logic       scl_s;

  // 2-FF synchronizers followed by a one-cycle history register
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_q    <= scl_sync[1];
      sda_q    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_q;
  assign scl_fall  = ~scl_s & scl_q;
  // SDA edges only count as conditions while SCL is stably high
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_eeprom_slave.sv
// 24xx-style I2C EEPROM target with a one-byte word address.
// Optional write protect: define I2C_EEPROM_WP_EN to add wp_i; while wp_i=1
// data bytes are NACKed and dropped, but the pointer still advances.
module i2c_eeprom_slave
  import i2c_eeprom_pkg::*;
#(
  parameter logic [6:0] ADDRESS    = 7'b1010_000,
  parameter int         MEM_BYTES  = 256,
  parameter int         PAGE_BYTES = 16
) (
  input  logic clk,
  input  logic rst_ni,
`ifdef I2C_EEPROM_WP_EN
  input  logic wp_i,
`endif
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_oe_o
);

  localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);

  logic          scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic [3:0]    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [AW-1:0] ptr;
  logic          rw, ack_ok, sda_oe;
  logic          wp_s;
  logic [7:0]    mem [MEM_BYTES];
  logic [7:0]    rx_byte, mem_rd;
  logic [AW-1:0] ptr_page_inc;
  logic          mem_we;
  i2c_det_e      det;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start_det(start_det),
    .stop_det (stop_det),
    .sda_s    (sda_s)
  );

`ifdef I2C_EEPROM_WP_EN
  logic [1:0] wp_sync;
  // write-protect pin synchronizer, same treatment as SDA
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) wp_sync <= 2'b11;
    else         wp_sync <= {wp_sync[0], wp_i};
  end
  assign wp_s = wp_sync[1];
`else
  assign wp_s = 1'b0;
`endif

  assign rx_byte      = {shreg[6:0], sda_s};
  assign mem_rd       = mem[ptr];
  // page write: low bits wrap inside the page, upper bits stay put
  assign ptr_page_inc = (ptr & ~PAGE_MASK) | ((ptr + PTR_ONE) & PAGE_MASK);
  assign sda_oe_o     = sda_oe;

  // classify this cycle's bus condition with START/STOP priority
  always_comb begin
    det = DET_NONE;
    if (start_det)     det = DET_START;
    else if (stop_det) det = DET_STOP;
  end

  // commit a data byte on the 8th rising edge of a WDATA byte
  assign mem_we = (det == DET_NONE) && scl_rise && (state == ST_WDATA) &&
                  (bit_cnt == 4'd7) && !wp_s;

  // memory array: contents intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= rx_byte;
  end

  // protocol FSM: sample on SCL rise, change SDA drive on SCL fall.
  // Receive states leave bit_cnt at 8 after the 8th rise; the next fall
  // enters the ACK state, and the fall after that ends the ACK bit.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      shreg   <= 8'h00;
      ptr     <= '0;
      rw      <= 1'b0;
      ack_ok  <= 1'b0;
      sda_oe  <= 1'b0;
    end else if (det == DET_START) begin
      state   <= ST_DEV;
      bit_cnt <= 4'd0;
      sda_oe  <= 1'b0;
    end else if (det == DET_STOP) begin
      state   <= ST_IDLE;
      bit_cnt <= 4'd0;
      sda_oe  <= 1'b0;
    end else if (scl_rise) begin
      case (state)
        ST_DEV, ST_WADDR, ST_WDATA: begin
          shreg   <= rx_byte;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd7) begin
            ack_ok <= 1'b1;
            if (state == ST_DEV) begin
              rw <= sda_s;
              if (rx_byte[7:1] != ADDRESS) state <= ST_IDLE;
            end else if (state == ST_WADDR) begin
              ptr <= rx_byte[AW-1:0];
            end else begin
              ack_ok <= !wp_s;
              ptr    <= ptr_page_inc;
            end
          end
        end
        ST_RDATA: bit_cnt <= bit_cnt + 4'd1;
        ST_MACK: begin
          if (sda_s) state   <= ST_IDLE;
          else       bit_cnt <= 4'd1;   // master ACKed: continue on next fall
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ST_DEV, ST_WADDR, ST_WDATA: begin
          if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            sda_oe  <= ack_ok;
            state   <= (state == ST_DEV)   ? ST_ACK_DEV   :
                       (state == ST_WADDR) ? ST_ACK_WADDR : ST_ACK_WDATA;
          end
        end
        ST_ACK_DEV: begin
          bit_cnt <= 4'd0;
          if (rw == I2C_RW_READ) begin
            shreg  <= mem_rd;
            sda_oe <= ~mem_rd[7];
            state  <= ST_RDATA;
          end else begin
            sda_oe <= 1'b0;
            state  <= ST_WADDR;
          end
        end
        ST_ACK_WADDR, ST_ACK_WDATA: begin
          bit_cnt <= 4'd0;
          sda_oe  <= 1'b0;
          state   <= ST_WDATA;
        end
        ST_RDATA: begin
          if (bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            sda_oe  <= 1'b0;
            ptr     <= ptr + PTR_ONE;
            state   <= ST_MACK;
          end else begin
            shreg  <= {shreg[6:0], 1'b0};
            sda_oe <= ~shreg[6];
          end
        end
        ST_MACK: begin
          if (bit_cnt == 4'd1) begin
            bit_cnt <= 4'd0;
            shreg   <= mem_rd;
            sda_oe  <= ~mem_rd[7];
            state   <= ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-banged I2C master, randomized data and
// addresses, expected values from an address-indexed byte model.
module tb_i2c_eeprom_slave;

  localparam int MEM  = 256;
  localparam int PAGE = 16;
  localparam logic [7:0] DEV_W = 8'hA0;
  localparam logic [7:0] DEV_R = 8'hA1;

  logic clk    = 1'b0;
  logic rst_ni = 1'b0;
  logic scl    = 1'b1;
  logic m_sda  = 1'b1;
  logic sda_oe;
  logic sda_line;
`ifdef I2C_EEPROM_WP_EN
  logic wp = 1'b0;
`endif

  // open-drain bus: either side can pull low
  assign sda_line = m_sda & ~sda_oe;
  always #5 clk = ~clk;

  i2c_eeprom_slave #(.ADDRESS(7'h50), .MEM_BYTES(MEM), .PAGE_BYTES(PAGE)) dut (
    .clk     (clk),
    .rst_ni  (rst_ni),
`ifdef I2C_EEPROM_WP_EN
    .wp_i    (wp),
`endif
    .scl_i   (scl),
    .sda_i   (sda_line),
    .sda_oe_o(sda_oe)
  );

  int total = 0;
  int bad   = 0;
  int model [MEM];   // -1 = never written
  int mptr  = 0;
  logic [7:0] wd [8];
  logic [7:0] rq [8];

  // ---------------- reference model ----------------
  task automatic model_write(input int addr, input int n);
    for (int i = 0; i < n; i++)
      model[(addr & ~(PAGE-1)) | ((addr + i) % PAGE)] = int'(wd[i]);
    mptr = (addr & ~(PAGE-1)) | ((addr + n) % PAGE);
  endtask

  function automatic logic [7:0] mval(input int a);
    return 8'(model[a % MEM]);
  endfunction

  // ---------------- bus driver ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(4);
    scl   = 1'b1; tick(6);
    m_sda = 1'b0; tick(6);
    scl   = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(4);
    scl   = 1'b1; tick(6);
    m_sda = 1'b1; tick(8);
  endtask

  task automatic bit_cycle(input logic b, output logic line, output logic oe);
    m_sda = b; tick(4);
    scl = 1'b1; tick(4);
    line = sda_line;
    oe   = sda_oe;
    tick(4);
    scl = 1'b0; tick(4);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic l;
    logic o;
    for (int b = 7; b >= 0; b--) bit_cycle(d[b], l, o);
    bit_cycle(1'b1, l, ack);
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d, output logic oe9);
    logic l;
    logic o;
    d = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      bit_cycle(1'b1, l, o);
      d[b] = l;
    end
    bit_cycle(nack, l, oe9);
  endtask

  task automatic do_write(input int addr, input int n, output logic [9:0] acks);
    logic a;
    logic [7:0] ab;
    ab = 8'(addr);
    acks = '0;
    i2c_start();
    wr_byte(DEV_W, a); acks[0] = a;
    wr_byte(ab, a);    acks[1] = a;
    for (int i = 0; i < n; i++) begin
      wr_byte(wd[i], a);
      acks[2+i] = a;
    end
    i2c_stop();
  endtask

  // rnd=1: random read (dummy write of address); rnd=0: current-address read
  task automatic do_read(input int addr, input bit rnd, input int n,
                         output logic [2:0] acks, output logic slv_in_mack);
    logic a;
    logic o;
    logic [7:0] ab;
    ab = 8'(addr);
    acks = 3'b011;
    slv_in_mack = 1'b0;
    for (int i = 0; i < 8; i++) rq[i] = 8'h00;
    i2c_start();
    if (rnd) begin
      wr_byte(DEV_W, a); acks[0] = a;
      wr_byte(ab, a);    acks[1] = a;
      i2c_start();
    end
    wr_byte(DEV_R, a); acks[2] = a;
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n-1, rq[i], o);
      slv_in_mack = slv_in_mack | o;
    end
    i2c_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; tick(3);
    total++;
    if (sda_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b want=0", sda_oe); end
    rst_ni = 1'b1; tick(6);
    mptr = 0;
    total++;
    if (sda_oe !== 1'b0) begin bad++; $display("FAIL idle_oe got=%b want=0", sda_oe); end
  endtask

  task automatic test_byte_write_read();
    logic [9:0] acks;
    logic [2:0] racks;
    logic sa;
    int addr;
    for (int it = 0; it < 4; it++) begin
      addr  = (it == 0) ? 'h10 : int'($urandom_range(0, MEM-1));
      wd[0] = (it == 0) ? 8'hA5 : 8'($urandom);
      do_write(addr, 1, acks);
      model_write(addr, 1);
      total++;
      if (acks !== 10'h007) begin bad++; $display("FAIL bw_acks addr=%0h got=%b want=0000000111", addr, acks); end
      do_read(addr, 1'b1, 1, racks, sa);
      mptr = (addr + 1) % MEM;
      total++;
      if (racks !== 3'b111 || sa !== 1'b0) begin
        bad++; $display("FAIL br_acks addr=%0h got=%b/%b want=111/0", addr, racks, sa);
      end
      total++;
      if (rq[0] !== mval(addr)) begin bad++; $display("FAIL br_data addr=%0h got=%0h want=%0h", addr, rq[0], mval(addr)); end
    end
  endtask

  task automatic test_addr_filter();
    logic [9:0] acks;
    logic [2:0] racks;
    logic sa, a1, a2, a3;
    logic [7:0] exp;
    wd[0] = 8'($urandom); wd[1] = 8'($urandom);
    do_write('h40, 2, acks);
    model_write('h40, 2);
    do_read('h40, 1'b1, 1, racks, sa);
    mptr = 'h41;
    i2c_start();
    wr_byte(8'hA2, a1);
    wr_byte(8'h00, a2);
    wr_byte(8'hFF, a3);
    i2c_stop();
    total++;
    if (a1 !== 1'b0) begin bad++; $display("FAIL filter_dev_ack got=%b want=0", a1); end
    total++;
    if ({a2, a3} !== 2'b00) begin bad++; $display("FAIL filter_follow_ack got=%b want=00", {a2, a3}); end
    exp = mval(mptr);
    do_read(0, 1'b0, 1, racks, sa);
    mptr = (mptr + 1) % MEM;
    total++;
    if (rq[0] !== exp || racks !== 3'b111) begin
      bad++; $display("FAIL filter_cur_read got=%0h/%b want=%0h/111", rq[0], racks, exp);
    end
  endtask

  task automatic test_page_wrap();
    logic [9:0] acks;
    logic [2:0] racks;
    logic sa;
    wd[0] = 8'($urandom);
    do_write('h10, 1, acks);
    model_write('h10, 1);
    for (int i = 0; i < 4; i++) wd[i] = 8'(i + 1);
    do_write('h0E, 4, acks);
    model_write('h0E, 4);
    total++;
    if (acks !== 10'h03F) begin bad++; $display("FAIL pw_acks got=%b want=0000111111", acks); end
    do_read('h0E, 1'b1, 2, racks, sa);
    total++;
    if (rq[0] !== mval('h0E) || rq[1] !== mval('h0F)) begin
      bad++; $display("FAIL pw_0e got=%0h,%0h want=%0h,%0h", rq[0], rq[1], mval('h0E), mval('h0F));
    end
    do_read('h00, 1'b1, 2, racks, sa);
    total++;
    if (rq[0] !== mval('h00) || rq[1] !== mval('h01)) begin
      bad++; $display("FAIL pw_00 got=%0h,%0h want=%0h,%0h", rq[0], rq[1], mval('h00), mval('h01));
    end
    do_read('h10, 1'b1, 1, racks, sa);
    mptr = 'h11;
    total++;
    if (rq[0] !== mval('h10)) begin bad++; $display("FAIL pw_10 got=%0h want=%0h", rq[0], mval('h10)); end
  endtask

  task automatic test_seq_read();
    logic [9:0] acks;
    logic [2:0] racks;
    logic sa;
    wd[0] = 8'h11; wd[1] = 8'h22;
    do_write('hFE, 2, acks);
    model_write('hFE, 2);
    do_read('hFE, 1'b1, 3, racks, sa);
    mptr = ('hFE + 3) % MEM;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rq[i] !== mval('hFE + i)) begin
        bad++; $display("FAIL seq_data%0d got=%0h want=%0h", i, rq[i], mval('hFE + i));
      end
    end
    total++;
    if (racks !== 3'b111 || sa !== 1'b0 || sda_oe !== 1'b0) begin
      bad++; $display("FAIL seq_release got=%b/%b/%b want=111/0/0", racks, sa, sda_oe);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] acks, exp_acks;
    logic [2:0] racks;
    logic sa;
    int addr, n;
    for (int it = 0; it < 6; it++) begin
      addr = int'($urandom_range(0, MEM-1));
      n    = int'($urandom_range(1, 5));
      for (int i = 0; i < n; i++) wd[i] = 8'($urandom);
      do_write(addr, n, acks);
      model_write(addr, n);
      exp_acks = 10'((1 << (n + 2)) - 1);
      total++;
      if (acks !== exp_acks) begin bad++; $display("FAIL b2b_acks it=%0d got=%b want=%b", it, acks, exp_acks); end
      do_read(addr, 1'b1, n, racks, sa);
      mptr = (addr + n) % MEM;
      total++;
      if (racks !== 3'b111 || sa !== 1'b0) begin bad++; $display("FAIL b2b_racks it=%0d got=%b/%b", it, racks, sa); end
      for (int i = 0; i < n; i++) begin
        if (model[(addr + i) % MEM] >= 0) begin
          total++;
          if (rq[i] !== mval(addr + i)) begin
            bad++; $display("FAIL b2b_data it=%0d addr=%0h got=%0h want=%0h", it, (addr + i) % MEM, rq[i], mval(addr + i));
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] acks;
    logic [2:0] racks;
    logic sa, a, l, o;
    logic [7:0] exp0;
    wd[0] = 8'h00; wd[1] = 8'h5A;
    do_write('h30, 2, acks);
    model_write('h30, 2);
    // reset while the target is pulling SDA low for a read data bit
    i2c_start();
    wr_byte(DEV_W, a); wr_byte(8'h30, a);
    i2c_start();
    wr_byte(DEV_R, a);
    m_sda = 1'b1; tick(4);
    scl = 1'b1; tick(4);
    total++;
    if (sda_oe !== 1'b1) begin bad++; $display("FAIL rmid_rd_drive got=%b want=1", sda_oe); end
    rst_ni = 1'b0; #1;
    total++;
    if (sda_oe !== 1'b0) begin bad++; $display("FAIL rmid_rd_oe got=%b want=0", sda_oe); end
    tick(4); rst_ni = 1'b1; tick(8);
    // reset during the 5th data bit of a write
    i2c_start();
    wr_byte(DEV_W, a); wr_byte(8'h31, a);
    for (int b = 0; b < 4; b++) bit_cycle(1'b1, l, o);
    m_sda = 1'b1; tick(4);
    scl = 1'b1; tick(4);
    rst_ni = 1'b0; #1;
    total++;
    if (sda_oe !== 1'b0) begin bad++; $display("FAIL rmid_wr_oe got=%b want=0", sda_oe); end
    tick(4); rst_ni = 1'b1; tick(4);
    scl = 1'b0; tick(4);
    for (int b = 0; b < 3; b++) bit_cycle(1'b1, l, o);
    bit_cycle(1'b1, l, o);
    i2c_stop();
    mptr = 0;
    total++;
    if (o !== 1'b0) begin bad++; $display("FAIL rmid_no_ack got=%b want=0", o); end
    exp0 = mval(0);
    do_read(0, 1'b0, 1, racks, sa);
    mptr = 1;
    total++;
    if (rq[0] !== exp0 || racks !== 3'b111) begin
      bad++; $display("FAIL rmid_ptr0 got=%0h/%b want=%0h/111", rq[0], racks, exp0);
    end
    do_read('h31, 1'b1, 1, racks, sa);
    mptr = 'h32;
    total++;
    if (rq[0] !== mval('h31)) begin bad++; $display("FAIL rmid_target got=%0h want=%0h", rq[0], mval('h31)); end
  endtask

`ifdef I2C_EEPROM_WP_EN
  task automatic test_write_protect();
    logic [9:0] acks;
    logic [2:0] racks;
    logic sa;
    wd[0] = 8'($urandom);
    do_write('h20, 1, acks);
    model_write('h20, 1);
    wp = 1'b1; tick(4);
    wd[0] = ~mval('h20);
    do_write('h20, 1, acks);
    mptr = 'h21;   // pointer advances even though nothing is stored
    total++;
    if (acks !== 10'h003) begin bad++; $display("FAIL wp_acks got=%b want=0000000011", acks); end
    wp = 1'b0; tick(4);
    do_read('h20, 1'b1, 1, racks, sa);
    total++;
    if (rq[0] !== mval('h20)) begin bad++; $display("FAIL wp_data got=%0h want=%0h", rq[0], mval('h20)); end
  endtask
`endif

  initial begin
    for (int i = 0; i < MEM; i++) model[i] = -1;
    test_reset();
    test_byte_write_read();
    test_addr_filter();
    test_page_wrap();
    test_seq_read();
    test_back_to_back();
    test_reset_mid();
`ifdef I2C_EEPROM_WP_EN
    test_write_protect();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
